// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keycode capture with decoder ack handshake, optional typematic repeat filter and FWFT FIFO.
// Latency: valid@N -> ack and FIFO entry visible at N+2; a full FIFO drops the code and sets sticky overflow.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int HOLDOFF_CYCLES = 12500000,
    parameter int KEY_W          = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          kbd_valid,
    input  logic [KEY_W-1:0]              kbd_keycode,
    output logic                          kbd_ack,
    input  logic                          repeat_filter_en,
    input  logic                          rd_req,
    output logic [KEY_W-1:0]              rd_data,
    output logic                          rd_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_C  = HW'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_CLR} state_t;

    state_t            state_q;
    logic              ack_q;
    logic [KEY_W-1:0]  cap_q;
    logic [KEY_W-1:0]  last_q;
    logic [HW-1:0]     hold_q, hold_d;
    logic [KEY_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              ovf_q;

    logic drop, push_req, full, do_pop, do_push, ovf_set;

    always_comb begin
        drop     = repeat_filter_en && (cap_q == last_q) && (hold_q != '0);
        push_req = (state_q == CAPTURE) && !drop;
        full     = (count_q == DEPTH_C);
        do_pop   = rd_req && (count_q != '0);
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        do_push  = push_req && (!full || do_pop);
        ovf_set  = push_req && full && !do_pop;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        hold_d = hold_q;
        if (state_q == CAPTURE) begin
            hold_d = HOLD_C;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kbd_valid) begin
                        cap_q   <= kbd_keycode;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end
                ACK: begin
                    state_q <= WAIT_CLR;
                    ack_q   <= 1'b0;
                end
                WAIT_CLR: begin
                    if (!kbd_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= '0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == CAPTURE) begin
                last_q <= cap_q;
            end
            hold_q  <= hold_d;
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (ovf_clear) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    // Gating with reset keeps the decoder from seeing an ack for a capture that reset discards.
    assign kbd_ack    = ack_q && !reset;
    assign rd_empty   = (count_q == '0);
    assign rd_data    = rd_empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized and directed bench for ps2_kbd_ctrl against a queue/time based reference model.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int HOLD  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        kbd_valid = 1'b0;
    logic [23:0] kbd_keycode = '0;
    logic        kbd_ack;
    logic        repeat_filter_en = 1'b0;
    logic        rd_req = 1'b0;
    logic [23:0] rd_data;
    logic        rd_empty;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        ovf_clear = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [23:0] mq[$];
    bit          m_ovf;
    logic [23:0] m_last;
    int          m_prev;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD), .KEY_W(24)) dut (
        .clk(clk), .reset(reset), .kbd_valid(kbd_valid), .kbd_keycode(kbd_keycode),
        .kbd_ack(kbd_ack), .repeat_filter_en(repeat_filter_en), .rd_req(rd_req),
        .rd_data(rd_data), .rd_empty(rd_empty), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [23:0] m_head();
        return (mq.size() > 0) ? mq[0] : 24'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_last = '0;
        m_prev = -1;
    endtask

    // Capture at cycle t: filter by time since last capture, optional same-cycle pop, bounded push.
    task automatic model_capture(input logic [23:0] code, input int t, input bit pop,
                                 input bit filt, input bit clr);
        bit drop;
        bit ev;
        drop = filt && (m_prev >= 0) && (code == m_last) && ((t - m_prev) <= HOLD);
        if (pop && mq.size() > 0) mq.delete(0);
        ev = 1'b0;
        if (!drop) begin
            if (mq.size() < DEPTH) mq.push_back(code);
            else ev = 1'b1;
        end
        if (ev) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_last = code;
        m_prev = t;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        kbd_valid = 1'b0;
        rd_req = 1'b0;
        ovf_clear = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Entered and left at a negedge with the controller idle.
    task automatic send_key(input logic [23:0] code, input int gap, input bit pop, input bit clr);
        int          t_cap;
        logic [3:0]  ec;
        logic [23:0] eh;
        repeat (gap) @(negedge clk);
        kbd_keycode = code;
        kbd_valid   = 1'b1;
        t_cap = cyc + 1;
        @(negedge clk);
        vectors++;
        if (kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_early code=%h got=%b want=0", code, kbd_ack);
        end
        if (pop) begin
            eh = m_head();
            vectors++;
            if (rd_data !== eh) begin
                miscompares++;
                $display("FAIL head_before_pop got=%h want=%h", rd_data, eh);
            end
            rd_req = 1'b1;
        end
        if (clr) ovf_clear = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        ovf_clear = 1'b0;
        model_capture(code, t_cap, pop, repeat_filter_en, clr);
        ec = 4'(mq.size());
        eh = m_head();
        vectors++;
        if (kbd_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_pulse code=%h got=%b want=1", code, kbd_ack);
        end
        vectors++;
        if (fifo_count !== ec || rd_empty !== (ec == 0) || rd_data !== eh) begin
            miscompares++;
            $display("FAIL fifo_after_capture code=%h got cnt=%0d empty=%b head=%h want cnt=%0d empty=%b head=%h",
                     code, fifo_count, rd_empty, rd_data, ec, (ec == 0), eh);
        end
        vectors++;
        if (overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL overflow_after_capture code=%h got=%b want=%b", code, overflow, m_ovf);
        end
        @(negedge clk);
        vectors++;
        if (kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_width code=%h got=%b want=0", code, kbd_ack);
        end
        kbd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read();
        logic [23:0] eh;
        logic [3:0]  ec;
        eh = m_head();
        vectors++;
        if (rd_data !== eh) begin
            miscompares++;
            $display("FAIL read_head got=%h want=%h", rd_data, eh);
        end
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        if (mq.size() > 0) mq.delete(0);
        ec = 4'(mq.size());
        eh = m_head();
        vectors++;
        if (fifo_count !== ec || rd_empty !== (ec == 0) || rd_data !== eh) begin
            miscompares++;
            $display("FAIL after_read got cnt=%0d empty=%b head=%h want cnt=%0d empty=%b head=%h",
                     fifo_count, rd_empty, rd_data, ec, (ec == 0), eh);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset();
        vectors++;
        if (rd_empty !== 1'b1 || fifo_count !== 4'd0 || rd_data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_fifo got empty=%b cnt=%0d data=%h want 1/0/0", rd_empty, fifo_count, rd_data);
        end
        vectors++;
        if (overflow !== 1'b0 || kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got ovf=%b ack=%b want 0/0", overflow, kbd_ack);
        end
    endtask

    task automatic test_single_key();
        repeat_filter_en = 1'b0;
        send_key(24'h00001D, 0, 1'b0, 1'b0);
        vectors++;
        if (rd_data !== 24'h00001D || fifo_count !== 4'd1) begin
            miscompares++;
            $display("FAIL single_key got data=%h cnt=%0d want 00001d/1", rd_data, fifo_count);
        end
        do_read();
        vectors++;
        if (rd_empty !== 1'b1 || rd_data !== 24'h0) begin
            miscompares++;
            $display("FAIL single_pop got empty=%b data=%h want 1/0", rd_empty, rd_data);
        end
        // Reading an empty FIFO must not disturb it.
        do_read();
    endtask

    task automatic test_typematic();
        for (int f = 1; f >= 0; f--) begin
            apply_reset();
            repeat_filter_en = f[0];
            send_key(24'h1C, 0, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) send_key(24'h1C, 36, 1'b0, 1'b0);
            send_key(24'h1C, 150, 1'b0, 1'b0);
            vectors++;
            if (fifo_count !== (f ? 4'd2 : 4'd6)) begin
                miscompares++;
                $display("FAIL typematic filt=%0d got cnt=%0d want %0d", f, fifo_count, f ? 2 : 6);
            end
            while (mq.size() > 0) do_read();
        end
    endtask

    task automatic test_alternating();
        apply_reset();
        repeat_filter_en = 1'b1;
        send_key(24'h1C, 0, 1'b0, 1'b0);
        send_key(24'h1B, 6, 1'b0, 1'b0);
        send_key(24'h1C, 6, 1'b0, 1'b0);
        vectors++;
        if (fifo_count !== 4'd3 || rd_data !== 24'h1C) begin
            miscompares++;
            $display("FAIL alternating got cnt=%0d head=%h want 3/00001c", fifo_count, rd_data);
        end
        while (mq.size() > 0) do_read();
    endtask

    task automatic test_overflow_and_full_pop();
        logic [23:0] want[$];
        apply_reset();
        repeat_filter_en = 1'b0;
        for (int k = 0; k < 9; k++) send_key(24'h11 + 24'(k), 0, 1'b0, 1'b0);
        vectors++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1 || rd_data !== 24'h11) begin
            miscompares++;
            $display("FAIL overflow got cnt=%0d ovf=%b head=%h want 8/1/000011", fifo_count, overflow, rd_data);
        end
        // Overflow set and clear in the same cycle: the set wins.
        send_key(24'h30, 0, 1'b0, 1'b1);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        m_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        send_key(24'h20, 0, 1'b1, 1'b0);
        vectors++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop got cnt=%0d ovf=%b want 8/0", fifo_count, overflow);
        end
        for (int k = 0; k < 7; k++) want.push_back(24'h12 + 24'(k));
        want.push_back(24'h20);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (rd_data !== want[k]) begin
                miscompares++;
                $display("FAIL drain_order idx=%0d got=%h want=%h", k, rd_data, want[k]);
            end
            do_read();
        end
    endtask

    task automatic test_reset_in_ack();
        int t_cap;
        apply_reset();
        repeat_filter_en = 1'b0;
        kbd_keycode = 24'h00005A;
        kbd_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_in_reset got=%b want=0", kbd_ack);
        end
        @(negedge clk);
        vectors++;
        if (rd_empty !== 1'b1 || fifo_count !== 4'd0 || kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_op got empty=%b cnt=%0d ack=%b want 1/0/0", rd_empty, fifo_count, kbd_ack);
        end
        reset = 1'b0;
        model_reset();
        t_cap = cyc + 1;
        @(negedge clk);
        vectors++;
        if (kbd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL recapture_early got=%b want=0", kbd_ack);
        end
        @(negedge clk);
        model_capture(24'h00005A, t_cap, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (kbd_ack !== 1'b1 || fifo_count !== 4'd1 || rd_data !== 24'h00005A) begin
            miscompares++;
            $display("FAIL recapture got ack=%b cnt=%0d data=%h want 1/1/00005a", kbd_ack, fifo_count, rd_data);
        end
        @(negedge clk);
        kbd_valid = 1'b0;
        @(negedge clk);
        while (mq.size() > 0) do_read();
    endtask

    task automatic test_random();
        logic [23:0] code;
        int          sel;
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                case ($urandom_range(0, 3))
                    0: code = 24'h00001C;
                    1: code = 24'h00001B;
                    2: code = 24'h00E075;
                    default: code = 24'($urandom);
                endcase
                repeat_filter_en = 1'($urandom_range(0, 1));
                send_key(code, $urandom_range(0, 120), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            end else if (sel < 9) begin
                do_read();
            end else begin
                ovf_clear = 1'b1;
                @(negedge clk);
                ovf_clear = 1'b0;
                m_ovf = 1'b0;
                vectors++;
                if (overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_ovf_clear got=%b want=0", overflow);
                end
            end
        end
        while (mq.size() > 0) do_read();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_typematic();
        test_alternating();
        test_overflow_and_full_pop();
        test_reset_in_ack();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
